// File: rtl/axi_lite_sram_slv_if.sv
// AXI4-Lite bus bundle between the master-side bridge and the SRAM slave.
// Signal suffixes are written from the slave's point of view.
interface axi_lite_sram_slv_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  // Read address / read data channels
  logic [ADDR_W-1:0]   araddr_i;
  logic                arvalid_i;
  logic                arready_o;
  logic [DATA_W-1:0]   rdata_o;
  logic [1:0]          rresp_o;
  logic                rvalid_o;
  logic                rready_i;

  // Write address / write data / write response channels
  logic [ADDR_W-1:0]   awaddr_i;
  logic                awvalid_i;
  logic                awready_o;
  logic [DATA_W-1:0]   wdata_i;
  logic [DATA_W/8-1:0] wstrb_i;
  logic                wvalid_i;
  logic                wready_o;
  logic [1:0]          bresp_o;
  logic                bvalid_o;
  logic                bready_i;

  modport master (
    output araddr_i, arvalid_i, rready_i,
    output awaddr_i, awvalid_i, wdata_i, wstrb_i, wvalid_i, bready_i,
    input  arready_o, rdata_o, rresp_o, rvalid_o,
    input  awready_o, wready_o, bresp_o, bvalid_o
  );

  modport slave (
    input  araddr_i, arvalid_i, rready_i,
    input  awaddr_i, awvalid_i, wdata_i, wstrb_i, wvalid_i, bready_i,
    output arready_o, rdata_o, rresp_o, rvalid_o,
    output awready_o, wready_o, bresp_o, bvalid_o
  );
endinterface

// File: rtl/axi_lite_sram_slv.sv
// AXI4-Lite slave backed by a word-addressed SRAM. Independent read and write
// engines, each with a fixed programmable response latency. Addresses outside
// the window [BASE_ADDR, BASE_ADDR + 4*DEPTH) complete with DECERR.
module axi_lite_sram_slv #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       DEPTH     = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h8000_0000),
  parameter int unsigned       R_LAT     = 3,
  parameter int unsigned       W_LAT     = 3
) (
  input logic               clk_i,
  input logic               rst_i,
  axi_lite_sram_slv_if.slave bus
);

  localparam int unsigned       STRB_W      = DATA_W / 8;
  localparam int unsigned       IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] WIN_BYTES   = ADDR_W'(4 * DEPTH);
  localparam logic [1:0]        RESP_OKAY   = 2'b00;
  localparam logic [1:0]        RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_e;

  logic [DATA_W-1:0] mem [DEPTH];

  // Read engine state
  r_state_e          r_state_q, r_state_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [7:0]        rcnt_q, rcnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic              arready, rvalid;

  // Write engine state
  w_state_e          w_state_q, w_state_d;
  logic              aw_got_q, aw_got_d;
  logic              w_got_q, w_got_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic [7:0]        wcnt_q, wcnt_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              awready, wready, bvalid;
  logic              aw_fire, w_fire, mem_we;

  // Window decode: subtracting the base wraps addresses below it to huge
  // offsets, so one unsigned compare covers both window edges.
  logic [ADDR_W-1:0] r_off, w_off;
  logic              r_in_range, w_in_range;
  logic [IDX_W-1:0]  r_idx, w_idx;

  assign r_off      = raddr_q - BASE_ADDR;
  assign w_off      = waddr_q - BASE_ADDR;
  assign r_in_range = (r_off < WIN_BYTES);
  assign w_in_range = (w_off < WIN_BYTES);
  assign r_idx      = r_off[IDX_W+1:2];
  assign w_idx      = w_off[IDX_W+1:2];

  // Read next-state: accept AR, count down the latency, then present data
  // until the master takes it. Data is sampled from the array before any
  // write committing on the same edge lands.
  always_comb begin
    r_state_d = r_state_q;
    raddr_d   = raddr_q;
    rcnt_d    = rcnt_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    arready   = 1'b0;
    rvalid    = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        arready = 1'b1;
        if (bus.arvalid_i) begin
          raddr_d   = bus.araddr_i;
          rcnt_d    = 8'(R_LAT);
          r_state_d = R_WAIT;
        end
      end
      R_WAIT: begin
        if (rcnt_q == 8'd0) begin
          rdata_d   = r_in_range ? mem[r_idx] : '0;
          rresp_d   = r_in_range ? RESP_OKAY : RESP_DECERR;
          r_state_d = R_RESP;
        end else begin
          rcnt_d = rcnt_q - 8'd1;
        end
      end
      R_RESP: begin
        rvalid = 1'b1;
        if (bus.rready_i) begin
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read engine registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state_q <= R_IDLE;
      raddr_q   <= '0;
      rcnt_q    <= '0;
      rdata_q   <= '0;
      rresp_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      raddr_q   <= raddr_d;
      rcnt_q    <= rcnt_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  // Write next-state: capture AW and W independently in any order, start the
  // latency count once both are held, commit, then hold the response.
  // A reset in the commit cycle suppresses the array write.
  always_comb begin
    w_state_d = w_state_q;
    aw_got_d  = aw_got_q;
    w_got_d   = w_got_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    wcnt_d    = wcnt_q;
    bresp_d   = bresp_q;
    awready   = 1'b0;
    wready    = 1'b0;
    bvalid    = 1'b0;
    aw_fire   = 1'b0;
    w_fire    = 1'b0;
    mem_we    = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        awready = !aw_got_q;
        wready  = !w_got_q;
        aw_fire = bus.awvalid_i && !aw_got_q;
        w_fire  = bus.wvalid_i && !w_got_q;
        if (aw_fire) begin
          waddr_d  = bus.awaddr_i;
          aw_got_d = 1'b1;
        end
        if (w_fire) begin
          wdata_d = bus.wdata_i;
          wstrb_d = bus.wstrb_i;
          w_got_d = 1'b1;
        end
        if ((aw_got_q || aw_fire) && (w_got_q || w_fire)) begin
          wcnt_d    = 8'(W_LAT);
          w_state_d = W_WAIT;
        end
      end
      W_WAIT: begin
        if (wcnt_q == 8'd0) begin
          mem_we    = w_in_range && !rst_i;
          bresp_d   = w_in_range ? RESP_OKAY : RESP_DECERR;
          w_state_d = W_RESP;
        end else begin
          wcnt_d = wcnt_q - 8'd1;
        end
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bus.bready_i) begin
          aw_got_d  = 1'b0;
          w_got_d   = 1'b0;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write engine registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_state_q <= W_IDLE;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      wcnt_q    <= '0;
      bresp_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      aw_got_q  <= aw_got_d;
      w_got_q   <= w_got_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      wcnt_q    <= wcnt_d;
      bresp_q   <= bresp_d;
    end
  end

  // SRAM array: byte-enabled write, contents survive reset
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < int'(STRB_W); b++) begin
        if (wstrb_q[b]) begin
          mem[w_idx][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

  assign bus.arready_o = arready;
  assign bus.rvalid_o  = rvalid;
  assign bus.rdata_o   = rdata_q;
  assign bus.rresp_o   = rresp_q;
  assign bus.awready_o = awready;
  assign bus.wready_o  = wready;
  assign bus.bvalid_o  = bvalid;
  assign bus.bresp_o   = bresp_q;

endmodule

// File: tb/tb_axi_lite_sram_slv.sv
// Directed bench for axi_lite_sram_slv with a cycle-timestamp reference model.
module tb_axi_lite_sram_slv;

  localparam int unsigned R_LAT = 3;
  localparam int unsigned W_LAT = 3;
  localparam int unsigned DEPTH = 1024;
  localparam longint      BASE  = 64'h8000_0000;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  axi_lite_sram_slv_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  axi_lite_sram_slv #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .BASE_ADDR(32'h8000_0000),
    .R_LAT(R_LAT), .W_LAT(W_LAT)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (bus)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Single comparison point for every check in the bench
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit inWin(input longint a);
    return (a >= BASE) && (a < BASE + 4 * longint'(DEPTH));
  endfunction

  function automatic int wordOf(input longint a);
    return int'((a - BASE) >>> 2);
  endfunction

  // Reference model: every transaction is tracked by the sample index at
  // which its response must appear; memory is a sparse map of known words.
  bit             model_on = 1'b0;
  int             cyc = 0;
  bit             r_busy, r_vexp, r_known;
  int             r_due, w_due;
  longint         r_addr, w_addr;
  logic [31:0]    r_dexp, w_data;
  logic [1:0]     r_rexp, b_rexp;
  logic [3:0]     w_strb;
  bit             aw_have, w_have, w_busy, b_vexp;
  logic [31:0]    mdl_mem [int];

  bit             p_rst, p_arv, p_rr, p_awv, p_wv, p_br;
  logic [31:0]    p_araddr, p_awaddr, p_wdata;
  logic [3:0]     p_wstrb;

  // Advance the model by one clock edge using the inputs seen before that
  // edge, then compare every meaningful DUT output against it.
  always @(negedge clk_i) begin : scoreboard
    bit          ar_hs, aw_hs, w_hs, r_done, b_done, r_fire, commit;
    int          idx;
    logic [31:0] v;
    cyc++;
    if (p_rst) begin
      model_on = 1'b1;
      r_busy = 1'b0; r_vexp = 1'b0; r_dexp = '0; r_rexp = '0; r_known = 1'b1;
      aw_have = 1'b0; w_have = 1'b0; w_busy = 1'b0; b_vexp = 1'b0; b_rexp = '0;
    end else if (model_on) begin
      ar_hs  = !r_busy && p_arv;
      aw_hs  = !w_busy && !aw_have && p_awv;
      w_hs   = !w_busy && !w_have && p_wv;
      r_done = r_vexp && p_rr;
      b_done = b_vexp && p_br;
      r_fire = r_busy && !r_vexp && (cyc == r_due);
      commit = w_busy && !b_vexp && (cyc == w_due);
      if (r_fire) begin
        r_vexp = 1'b1;
        if (inWin(r_addr)) begin
          r_rexp = 2'b00;
          idx = wordOf(r_addr);
          r_known = mdl_mem.exists(idx);
          r_dexp = r_known ? mdl_mem[idx] : '0;
        end else begin
          r_rexp = 2'b11; r_dexp = '0; r_known = 1'b1;
        end
      end
      if (commit) begin
        b_vexp = 1'b1;
        if (inWin(w_addr)) begin
          b_rexp = 2'b00;
          idx = wordOf(w_addr);
          if (mdl_mem.exists(idx)) begin
            v = mdl_mem[idx];
            for (int b = 0; b < 4; b++) if (w_strb[b]) v[8*b +: 8] = w_data[8*b +: 8];
            mdl_mem[idx] = v;
          end else if (w_strb == 4'hF) begin
            mdl_mem[idx] = w_data;
          end
        end else begin
          b_rexp = 2'b11;
        end
      end
      if (r_done) begin r_vexp = 1'b0; r_busy = 1'b0; end
      if (ar_hs) begin r_busy = 1'b1; r_addr = longint'(p_araddr); r_due = cyc + int'(R_LAT) + 1; end
      if (b_done) begin b_vexp = 1'b0; w_busy = 1'b0; aw_have = 1'b0; w_have = 1'b0; end
      if (aw_hs) begin aw_have = 1'b1; w_addr = longint'(p_awaddr); end
      if (w_hs) begin w_have = 1'b1; w_data = p_wdata; w_strb = p_wstrb; end
      if (!w_busy && aw_have && w_have) begin w_busy = 1'b1; w_due = cyc + int'(W_LAT) + 1; end
    end
    if (model_on) begin
      checkOutput("arready", 32'(bus.arready_o), 32'(!r_busy));
      checkOutput("rvalid",  32'(bus.rvalid_o),  32'(r_vexp));
      checkOutput("awready", 32'(bus.awready_o), 32'(!w_busy && !aw_have));
      checkOutput("wready",  32'(bus.wready_o),  32'(!w_busy && !w_have));
      checkOutput("bvalid",  32'(bus.bvalid_o),  32'(b_vexp));
      if (r_vexp) begin
        checkOutput("rresp", 32'(bus.rresp_o), 32'(r_rexp));
        if (r_known) checkOutput("rdata", bus.rdata_o, r_dexp);
      end
      if (b_vexp) checkOutput("bresp", 32'(bus.bresp_o), 32'(b_rexp));
    end
    p_rst = rst_i;       p_arv = bus.arvalid_i; p_rr = bus.rready_i;
    p_awv = bus.awvalid_i; p_wv = bus.wvalid_i; p_br = bus.bready_i;
    p_araddr = bus.araddr_i; p_awaddr = bus.awaddr_i;
    p_wdata = bus.wdata_i;   p_wstrb = bus.wstrb_i;
  end

  // Write transaction: AW and W raised after their own delays; optionally
  // pulse reset a few cycles into the latency instead of collecting B.
  task automatic axiWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_delay, input int w_delay, input int rst_after,
                          output logic [1:0] resp, output int lat);
    int c = 0;
    bit aw_done = 1'b0, w_done = 1'b0, aw_hs, w_hs;
    resp = 2'b01;
    lat  = -1;
    bus.awaddr_i = addr; bus.wdata_i = data; bus.wstrb_i = strb;
    while (!(aw_done && w_done) && c < 40) begin
      bus.awvalid_i = !aw_done && (c >= aw_delay);
      bus.wvalid_i  = !w_done && (c >= w_delay);
      @(negedge clk_i);
      aw_hs = bus.awvalid_i && bus.awready_o;
      w_hs  = bus.wvalid_i && bus.wready_o;
      @(posedge clk_i); #1;
      aw_done |= aw_hs; w_done |= w_hs; c++;
    end
    bus.awvalid_i = 1'b0; bus.wvalid_i = 1'b0;
    if (!(aw_done && w_done)) begin
      checks++; errors++;
      $display("[TB] FAIL write_handshake: got timeout expected accept at %0t", $time);
      return;
    end
    if (rst_after >= 0) begin
      repeat (rst_after) begin @(posedge clk_i); #1; end
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      return;
    end
    lat = 0;
    while (lat < 300) begin
      @(negedge clk_i);
      if (bus.bvalid_o) begin resp = bus.bresp_o; break; end
      @(posedge clk_i); #1;
      lat++;
    end
    if (lat >= 300) begin
      checks++; errors++;
      $display("[TB] FAIL bvalid_wait: got timeout expected bvalid at %0t", $time);
    end
    @(posedge clk_i); #1;
  endtask

  // Read transaction with optional rready backpressure of 'hold' cycles
  task automatic axiRead(input logic [31:0] addr, input int hold,
                         output logic [31:0] data, output logic [1:0] resp, output int lat);
    int c = 0;
    bit hs = 1'b0;
    data = '0; resp = 2'b01; lat = -1;
    bus.araddr_i = addr; bus.arvalid_i = 1'b1; bus.rready_i = (hold == 0);
    while (!hs && c < 40) begin
      @(negedge clk_i);
      hs = bus.arready_o;
      @(posedge clk_i); #1;
      c++;
    end
    bus.arvalid_i = 1'b0;
    if (!hs) begin
      checks++; errors++;
      $display("[TB] FAIL read_handshake: got timeout expected accept at %0t", $time);
      bus.rready_i = 1'b1;
      return;
    end
    lat = 0;
    while (lat < 300) begin
      @(negedge clk_i);
      if (bus.rvalid_o) begin data = bus.rdata_o; resp = bus.rresp_o; break; end
      @(posedge clk_i); #1;
      lat++;
    end
    if (lat >= 300) begin
      checks++; errors++;
      $display("[TB] FAIL rvalid_wait: got timeout expected rvalid at %0t", $time);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk_i); #1;
      @(negedge clk_i);
      checkOutput("hold_rvalid",  32'(bus.rvalid_o), 32'd1);
      checkOutput("hold_rdata",   bus.rdata_o, data);
      checkOutput("hold_rresp",   32'(bus.rresp_o), 32'(resp));
      checkOutput("hold_arready", 32'(bus.arready_o), 32'd0);
    end
    @(posedge clk_i); #1;
    if (hold > 0) begin
      bus.rready_i = 1'b1;
      @(posedge clk_i); #1;
      @(negedge clk_i);
      checkOutput("arready_after_release", 32'(bus.arready_o), 32'd1);
      @(posedge clk_i); #1;
    end
  endtask

  // Directed scenarios with hand-computed expectations
  task automatic applyStimulus();
    logic [31:0] d;
    logic [1:0]  r, wr;
    int          lat, wlat;

    $display("[TB] reset and idle");
    @(negedge clk_i);
    checkOutput("t1_arready", 32'(bus.arready_o), 32'd1);
    checkOutput("t1_awready", 32'(bus.awready_o), 32'd1);
    checkOutput("t1_wready",  32'(bus.wready_o),  32'd1);
    checkOutput("t1_rvalid",  32'(bus.rvalid_o),  32'd0);
    checkOutput("t1_bvalid",  32'(bus.bvalid_o),  32'd0);
    @(posedge clk_i); #1;

    $display("[TB] write then read");
    axiWrite(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, -1, wr, lat);
    checkOutput("t2_bresp", 32'(wr), 32'd0);
    checkOutput("t2_blat", 32'(lat), 32'd4);
    axiRead(32'h8000_0010, 0, d, r, lat);
    checkOutput("t2_rdata", d, 32'hDEAD_BEEF);
    checkOutput("t2_rresp", 32'(r), 32'd0);
    checkOutput("t2_rlat", 32'(lat), 32'd4);

    $display("[TB] strobes with W ahead of AW");
    axiWrite(32'h8000_0010, 32'h1122_3344, 4'b0101, 3, 0, -1, wr, lat);
    checkOutput("t3_bresp", 32'(wr), 32'd0);
    axiRead(32'h8000_0010, 0, d, r, lat);
    checkOutput("t3_rdata", d, 32'hDE22_BE44);
    axiRead(32'h8000_0013, 0, d, r, lat);
    checkOutput("t3_lowbits_rdata", d, 32'hDE22_BE44);

    $display("[TB] AW ahead of W and empty strobe");
    axiWrite(32'h8000_0014, 32'h0123_4567, 4'hF, 0, 2, -1, wr, lat);
    checkOutput("t3_awfirst_bresp", 32'(wr), 32'd0);
    axiWrite(32'h8000_0014, 32'hFFFF_FFFF, 4'h0, 0, 0, -1, wr, lat);
    checkOutput("t3_nostrb_bresp", 32'(wr), 32'd0);
    axiRead(32'h8000_0014, 0, d, r, lat);
    checkOutput("t3_nostrb_rdata", d, 32'h0123_4567);

    $display("[TB] window edges");
    axiWrite(32'h8000_0000, 32'hA5A5_0001, 4'hF, 0, 0, -1, wr, lat);
    axiWrite(32'h8000_0FFC, 32'hCAFE_0FFC, 4'hF, 0, 0, -1, wr, lat);
    checkOutput("t4_lastword_bresp", 32'(wr), 32'd0);
    axiRead(32'h7FFF_FFFC, 0, d, r, lat);
    checkOutput("t4_below_rresp", 32'(r), 32'd3);
    checkOutput("t4_below_rdata", d, 32'd0);
    axiWrite(32'h8000_1000, 32'h5A5A_5A5A, 4'hF, 0, 0, -1, wr, lat);
    checkOutput("t4_above_bresp", 32'(wr), 32'd3);
    axiRead(32'h8000_0000, 0, d, r, lat);
    checkOutput("t4_word0_rdata", d, 32'hA5A5_0001);
    axiRead(32'h8000_0FFC, 0, d, r, lat);
    checkOutput("t4_lastword_rdata", d, 32'hCAFE_0FFC);
    checkOutput("t4_lastword_rresp", 32'(r), 32'd0);

    $display("[TB] read backpressure");
    axiRead(32'h8000_0010, 5, d, r, lat);
    checkOutput("t5_rdata", d, 32'hDE22_BE44);

    $display("[TB] same-word read and write commit");
    fork
      axiWrite(32'h8000_0010, 32'h9999_9999, 4'hF, 0, 0, -1, wr, wlat);
      axiRead(32'h8000_0010, 0, d, r, lat);
    join
    checkOutput("t7_collide_rdata", d, 32'hDE22_BE44);
    axiRead(32'h8000_0010, 0, d, r, lat);
    checkOutput("t7_after_rdata", d, 32'h9999_9999);

    $display("[TB] reset during write latency");
    axiWrite(32'h8000_0020, 32'h0BAD_F00D, 4'hF, 0, 0, -1, wr, lat);
    axiWrite(32'h8000_0020, 32'h5555_5555, 4'hF, 0, 0, 1, wr, lat);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      checkOutput("t6_no_bvalid", 32'(bus.bvalid_o), 32'd0);
      @(posedge clk_i); #1;
    end
    axiRead(32'h8000_0020, 0, d, r, lat);
    checkOutput("t6_rdata", d, 32'h0BAD_F00D);
  endtask

  initial begin
    bus.araddr_i = '0; bus.arvalid_i = 1'b0; bus.rready_i = 1'b1;
    bus.awaddr_i = '0; bus.awvalid_i = 1'b0;
    bus.wdata_i = '0; bus.wstrb_i = '0; bus.wvalid_i = 1'b0; bus.bready_i = 1'b1;
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    applyStimulus();
    repeat (3) @(posedge clk_i);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop if the flow ever stalls
  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: got stall expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule

// File: doc/axi_lite_sram_slv.md
Name: axi_lite_sram_slv

Overview:
AXI4-Lite slave memory model on the interconnect side. It consumes the read and write transactions that the master-side bridge drives into the interconnect. Read and write channels are independent, and each has a programmable fixed access latency so bridge timing paths can be exercised. It backs a word-addressed SRAM array and returns DECERR for addresses outside its window.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (fixed 32; wstrb is 4 bits)
DEPTH, 1024, number of 32-bit words
BASE_ADDR, 32'h8000_0000, first byte address of the window
R_LAT, 3, extra wait cycles between AR handshake and rvalid (0..255)
W_LAT, 3, extra wait cycles between AW+W capture and bvalid (0..255)

Ports:
clk_i  in  1  clock, all logic on posedge
rst_i  in  1  synchronous reset, active-high (asserted = `ysyx_23060251_rst_enable)
araddr_i  in  ADDR_W  read address
arvalid_i  in  1  read address valid
arready_o  out  1  read address ready
rdata_o  out  32  read data
rresp_o  out  2  read response (00 OKAY, 11 DECERR)
rvalid_o  out  1  read data valid
rready_i  in  1  read data ready
awaddr_i  in  ADDR_W  write address
awvalid_i  in  1  write address valid
awready_o  out  1  write address ready
wdata_i  in  32  write data
wstrb_i  in  4  byte enables
wvalid_i  in  1  write data valid
wready_o  out  1  write data ready
bresp_o  out  2  write response
bvalid_o  out  1  write response valid
bready_i  in  1  write response ready

Behaviour:
- Reset, synchronous: r_state=R_IDLE and w_state=W_IDLE. rvalid_o=0, bvalid_o=0, rdata_o=0, rresp_o=0, bresp_o=0. Captured-AW/W flags and both counters are cleared. SRAM contents are not reset.
- A reset mid-transaction abandons it. No SRAM write commits, and the valids are 0 from the next edge.
- Address decode: word index = (addr - BASE_ADDR) >> 2; bits [1:0] are ignored. The address is in range when BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH; otherwise the response is DECERR.
- Read FSM states: R_IDLE, R_WAIT, R_RESP.
  - R_IDLE: arready_o=1. On arvalid_i, latch the address, load rcnt=R_LAT and go to R_WAIT.
  - R_WAIT: if rcnt==0, register rdata_o (or 0 when out of range) and rresp_o, then go to R_RESP. Otherwise rcnt--.
  - R_RESP: rvalid_o=1 with rdata_o/rresp_o stable. On rready_i, go to R_IDLE.
  - arready_o=0 outside R_IDLE.
  - Timing: rvalid_o first rises R_LAT+1 cycles after the AR handshake edge (R_LAT=0 gives 1 cycle).
- Write FSM states: W_IDLE, W_WAIT, W_RESP.
  - W_IDLE: awready_o=1 until AW is captured; wready_o=1 until W is captured. AW and W may arrive in either order or in the same cycle.
  - When both are captured (including the capture cycle itself), load wcnt=W_LAT and go to W_WAIT.
  - W_WAIT: if wcnt==0, commit the write to the SRAM with wstrb byte-enables (no commit when out of range), register bresp_o and go to W_RESP. Otherwise wcnt--.
  - W_RESP: bvalid_o=1. On bready_i, clear the captured flags and go to W_IDLE.
  - Readies are 0 outside W_IDLE.
- Same-word collision: a read sampling in the same cycle that a write commits returns the pre-write data.
- wstrb_i=0: the transaction completes with OKAY and memory is unchanged.
- Back-to-back transactions: a new AR is accepted no earlier than the cycle after the rready handshake. The same holds for AW/W after the bready handshake.
- Valid/data hold: rvalid_o and bvalid_o never drop without the matching ready. Response payloads do not change while valid is high.

Test Plan:
1. Reset then idle: rst_i high 2 cycles -> rvalid_o=0, bvalid_o=0, arready_o=1, awready_o=1, wready_o=1 in the first cycle after reset.
2. Write then read, R_LAT=W_LAT=3: AW=0x8000_0010 and W=0xDEAD_BEEF with wstrb=F in the same cycle -> bvalid_o 4 cycles later, bresp=00. Then AR=0x8000_0010 -> rvalid_o 4 cycles after the handshake with rdata=0xDEAD_BEEF, rresp=00.
3. Byte strobes and ordering: W (0x1122_3344, wstrb=0101) presented 3 cycles before AW (0x8000_0010) -> a subsequent read returns 0xDE22_BE44.
4. Out of range: AR=0x7FFF_FFFC -> rresp=11, rdata=0. AW=0x8000_1000 -> bresp=11, and word 0 is unchanged.
5. Backpressure: rready_i held low 5 cycles -> rvalid_o and rdata_o stay stable and arready_o=0 throughout. Release -> arready_o=1 on the next cycle.
6. Reset mid-write: assert rst_i during W_WAIT for 0x8000_0020 -> no bvalid_o, and a later read of 0x8000_0020 returns its prior value.
